// File: rtl/writeback_regfile.sv
// -----------------------------------------------------------------------------
// writeback_regfile
//
// Write-back stage and architectural integer register file for a 5-stage
// RISC-V pipeline. Consumes the MEM/WB pipeline register outputs, selects the
// write-back value, commits it to the 32 x XLEN register file and serves the
// two ID-stage read ports with same-cycle write-to-read bypass. A free-running
// counter tracks the number of committed register writes.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-high reset (clears regs + counter)
//   readdata       in   XLEN  load data from MEM/WB
//   result_alu_out in   XLEN  ALU result from MEM/WB
//   rd             in   5     destination register index
//   Memtoreg       in   1     1 = write back readdata, 0 = result_alu_out
//   Regwrite       in   1     write enable from MEM/WB
//   rs1, rs2       in   5     ID-stage read indices
//   rdata1, rdata2 out  XLEN  read data (combinational, bypassed)
//   wb_data        out  XLEN  selected write-back value (combinational)
//   wb_we          out  1     effective write strobe
//   wb_count       out  CNT_W number of committed register writes (wraps)
// -----------------------------------------------------------------------------
module writeback_regfile #(
    parameter int XLEN  = 64,
    parameter int NREG  = 32,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   readdata,
    input  logic [XLEN-1:0]   result_alu_out,
    input  logic [4:0]        rd,
    input  logic              Memtoreg,
    input  logic              Regwrite,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    output logic [XLEN-1:0]   rdata1,
    output logic [XLEN-1:0]   rdata2,
    output logic [XLEN-1:0]   wb_data,
    output logic              wb_we,
    output logic [CNT_W-1:0]  wb_count
);

    logic [XLEN-1:0]  regs_q [NREG];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Write-back mux; also feeds EX-stage forwarding, so it stays live in reset.
    assign wb_data = Memtoreg ? readdata : result_alu_out;

    // x0 is hardwired: a write to it never commits, strobes, or counts.
    assign wb_we = Regwrite && (rd != 5'd0) && !reset;

    assign cnt_d = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            cnt_q <= '0;
        end else if (wb_we) begin
            regs_q[rd] <= wb_data;
            cnt_q      <= cnt_d;
        end
    end

    // Bypass returns exactly the value committed at the edge ending this cycle,
    // so decode never sees stale data. rs == 0 must win over the bypass.
    assign rdata1 = (reset || rs1 == 5'd0) ? '0 :
                    (wb_we && rd == rs1)   ? wb_data : regs_q[rs1];
    assign rdata2 = (reset || rs2 == 5'd0) ? '0 :
                    (wb_we && rd == rs2)   ? wb_data : regs_q[rs2];

    assign wb_count = cnt_q;

endmodule

// File: tb/tb_writeback_regfile.sv
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] readdata, result_alu_out;
    logic [4:0]  rd, rs1, rs2;
    logic        Memtoreg, Regwrite;
    logic [63:0] rdata1, rdata2, wb_data;
    logic        wb_we;
    logic [31:0] wb_count;

    // Second instance with a narrow counter so the wrap is reached naturally.
    logic [63:0] rdata1_w, rdata2_w, wb_data_w;
    logic        wb_we_w;
    logic [3:0]  wb_count_w;

    always #5 clk = ~clk;

    writeback_regfile dut (
        .clk(clk), .reset(reset), .readdata(readdata), .result_alu_out(result_alu_out),
        .rd(rd), .Memtoreg(Memtoreg), .Regwrite(Regwrite), .rs1(rs1), .rs2(rs2),
        .rdata1(rdata1), .rdata2(rdata2), .wb_data(wb_data), .wb_we(wb_we),
        .wb_count(wb_count)
    );

    writeback_regfile #(.XLEN(64), .NREG(32), .CNT_W(4)) dut_wrap (
        .clk(clk), .reset(reset), .readdata(readdata), .result_alu_out(result_alu_out),
        .rd(rd), .Memtoreg(Memtoreg), .Regwrite(Regwrite), .rs1(rs1), .rs2(rs2),
        .rdata1(rdata1_w), .rdata2(rdata2_w), .wb_data(wb_data_w), .wb_we(wb_we_w),
        .wb_count(wb_count_w)
    );

    typedef struct {
        logic [63:0] r1;
        logic [63:0] r2;
        logic [63:0] wd;
        logic        we;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: architectural state as committed so far.
    logic [63:0] m_reg [32];
    logic [31:0] m_cnt;
    int unsigned m_cnt4;

    int n_cmp = 0;
    int n_bad = 0;
    bit stim_done = 1'b0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", nm, got, want, $time);
        end
    endtask

    // Drive one cycle's worth of MEM/WB + ID inputs at the falling edge and
    // record what the outputs must look like before the next rising edge.
    task automatic drive(input bit rst, input bit rw, input bit mtr,
                         input logic [63:0] ld, input logic [63:0] alu,
                         input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
        exp_t e;
        logic [63:0] val;
        bit commits;
        @(negedge clk);
        reset = rst; Regwrite = rw; Memtoreg = mtr;
        readdata = ld; result_alu_out = alu; rd = d; rs1 = a; rs2 = b;
        if (rst) begin
            // Asynchronous clear: the state is gone the moment reset rises.
            foreach (m_reg[i]) m_reg[i] = '0;
            m_cnt  = '0;
            m_cnt4 = 0;
        end
        val     = mtr ? ld : alu;
        commits = rw && (d != 0) && !rst;
        // A read returns the value register a holds after this cycle's commit.
        e.r1   = (rst || a == 0) ? 64'd0 : ((commits && d == a) ? val : m_reg[a]);
        e.r2   = (rst || b == 0) ? 64'd0 : ((commits && d == b) ? val : m_reg[b]);
        e.wd   = val;
        e.we   = commits;
        e.cnt  = m_cnt;
        e.cnt4 = m_cnt4[3:0];
        exp_q.push_back(e);
        if (commits) begin
            m_reg[d] = val;
            m_cnt    = m_cnt + 1;
            m_cnt4   = (m_cnt4 + 1) % 16;
        end
    endtask

    // Monitor: samples the combinational outputs mid-cycle, well away from edges.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rdata1",   rdata1,            e.r1);
                check("rdata2",   rdata2,            e.r2);
                check("wb_data",  wb_data,           e.wd);
                check("wb_we",    {63'd0, wb_we},    {63'd0, e.we});
                check("wb_count", {32'd0, wb_count}, {32'd0, e.cnt});
                check("wb_count_wrap", {60'd0, wb_count_w}, {60'd0, e.cnt4});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0]  d, a, b;
        logic [63:0] ld, alu;
        bit rst, rw, mtr;
        reset = 1'b1; Regwrite = 1'b0; Memtoreg = 1'b0;
        readdata = '0; result_alu_out = '0; rd = '0; rs1 = '0; rs2 = '0;
        foreach (m_reg[i]) m_reg[i] = '0;
        m_cnt = '0; m_cnt4 = 0;

        drive(1, 0, 0, 64'h0, 64'h0, 5'd0, 5'd1, 5'd2);
        // ALU write-back; readdata is a decoy.
        drive(0, 1, 0, 64'hFFFF, 64'h1234, 5'd5, 5'd0, 5'd5);
        drive(0, 0, 0, 64'h0, 64'h0, 5'd0, 5'd5, 5'd6);
        // Load write-back with both ports bypassing.
        drive(0, 1, 1, 64'h0000_0000_8000_0001, 64'h55, 5'd7, 5'd7, 5'd7);
        drive(0, 0, 1, 64'h0, 64'h0, 5'd0, 5'd7, 5'd7);
        // x0 protection: no strobe, no count, never bypassed.
        drive(0, 1, 0, 64'h0, 64'hFF, 5'd0, 5'd0, 5'd0);
        drive(0, 0, 0, 64'h0, 64'h0, 5'd0, 5'd0, 5'd5);
        // Bubble over a live register.
        drive(0, 1, 0, 64'h0, 64'h33, 5'd3, 5'd0, 5'd0);
        drive(0, 0, 1, 64'hBAD, 64'hBAD, 5'd3, 5'd3, 5'd3);
        drive(0, 0, 0, 64'hBAD, 64'hBAD, 5'd3, 5'd3, 5'd3);
        // Back-to-back writes to x9.
        drive(0, 1, 0, 64'h0, 64'd1, 5'd9, 5'd9, 5'd1);
        drive(0, 1, 1, 64'd2, 64'h0, 5'd9, 5'd9, 5'd9);
        drive(0, 1, 0, 64'h0, 64'd3, 5'd9, 5'd2, 5'd9);
        drive(0, 0, 0, 64'h0, 64'h0, 5'd0, 5'd9, 5'd9);
        // x5 = 0xDEAD, then reset mid-cycle while a write is presented.
        drive(0, 1, 0, 64'h0, 64'hDEAD, 5'd5, 5'd5, 5'd0);
        drive(0, 0, 0, 64'h0, 64'h0, 5'd0, 5'd5, 5'd5);
        for (int i = 0; i < 32; i++)
            drive(1, 1, 0, 64'h0, 64'hABCD_0000 + 64'(i), 5'(i), 5'(i), 5'(31 - i));
        // First write after release lands on the first edge.
        drive(0, 1, 0, 64'h0, 64'h77, 5'd4, 5'd4, 5'd5);
        drive(0, 0, 0, 64'h0, 64'h0, 5'd0, 5'd4, 5'd5);

        // Randomized traffic, including occasional resets and forced aliasing.
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 79) == 0);
            rw  = ($urandom_range(0, 3) != 0);
            mtr = $urandom_range(0, 1);
            ld  = {$urandom, $urandom};
            alu = {$urandom, $urandom};
            d   = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            a   = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
            b   = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
            drive(rst, rw, mtr, ld, alu, d, a, b);
        end
        drive(0, 0, 0, 64'h0, 64'h0, 5'd0, 5'd0, 5'd0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
